// File: rtl/ras_ctrl.sv
// Fetch-stage return-address-stack driver: predecodes JAL/JALR, drives ras push/pop and
// turns a popped address into a held fetch redirect under a valid/ready handshake.
module ras_ctrl #(
  parameter int USE_X5 = 1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      if_instr,
  input  logic             flush,
  output logic             ras_push,
  output logic             ras_pop,
  output logic [31:0]      ras_wdata,
  input  logic [31:0]      ras_rdata,
  input  logic             ras_valid,
  input  logic             ras_empty,
  input  logic             ras_full,
  output logic             redir_valid,
  output logic [31:0]      redir_pc,
  input  logic             redir_ready,
  output logic [CNT_W-1:0] ret_pred_cnt,
  output logic [CNT_W-1:0] ret_miss_cnt
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PUSH2 = 2'd1;
  localparam logic [1:0] S_REDIR = 2'd2;

  logic [1:0]  state;
  logic [31:0] push_addr;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1;
  logic [2:0]  funct3;
  logic        link_rd, link_rs1, is_jal, is_jalr;
  logic        dec_push, dec_pop, dec_ptp;
  logic        accept, push2, pop_hit, pop_miss, take;
  logic [31:0] ret_addr;
  logic        unused_in;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || ((USE_X5 != 0) && (r == 5'd5));
  endfunction

  assign opcode   = if_instr[6:0];
  assign rd       = if_instr[11:7];
  assign funct3   = if_instr[14:12];
  assign rs1      = if_instr[19:15];
  assign link_rd  = is_link(rd);
  assign link_rs1 = is_link(rs1);
  assign is_jal   = (opcode == 7'b1101111);
  assign is_jalr  = (opcode == 7'b1100111) && (funct3 == 3'b000);

  // rd==rs1 with both links is a plain call; differing links make a coroutine swap
  assign dec_push = (is_jal & link_rd) | (is_jalr & link_rd & (~link_rs1 | (rd == rs1)));
  assign dec_pop  = is_jalr & link_rs1 & (~link_rd | (rd != rs1));
  assign dec_ptp  = is_jalr & link_rd & link_rs1 & (rd != rs1);

  assign ret_addr  = if_pc + 32'd4;
  assign if_ready  = (state == S_IDLE) & ~flush;
  assign accept    = if_valid & if_ready;
  assign push2     = (state == S_PUSH2) & ~flush;
  assign ras_push  = (accept & dec_push) | push2;
  assign ras_pop   = accept & dec_pop;
  assign ras_wdata = push2 ? push_addr : ((accept & dec_push) ? ret_addr : 32'd0);
  assign pop_hit   = ras_pop & ras_valid;
  assign pop_miss  = ras_pop & ~ras_valid & ras_empty;
  assign take      = redir_valid & redir_ready;

  // The ras discards pushes when full, so the full flag never stalls fetch.
  assign unused_in = ^{ras_full, if_instr[31:20]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      redir_valid <= 1'b0;
      redir_pc    <= 32'd0;
      push_addr   <= 32'd0;
    end else if (flush) begin
      state       <= S_IDLE;
      redir_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop_hit) begin
            redir_valid <= 1'b1;
            redir_pc    <= ras_rdata & ~32'd1;
          end
          if (accept & dec_ptp) begin
            push_addr <= ret_addr;
            state     <= S_PUSH2;
          end else if (pop_hit) begin
            state <= S_REDIR;
          end
        end
        S_PUSH2: begin
          if (take) begin
            redir_valid <= 1'b0;
            state       <= S_IDLE;
          end else begin
            state <= redir_valid ? S_REDIR : S_IDLE;
          end
        end
        S_REDIR: begin
          if (take) begin
            redir_valid <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Statistics saturate rather than wrap so long runs stay meaningful.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ret_pred_cnt <= '0;
      ret_miss_cnt <= '0;
    end else begin
      if (pop_hit && (ret_pred_cnt != {CNT_W{1'b1}}))
        ret_pred_cnt <= ret_pred_cnt + 1'b1;
      if (pop_miss && (ret_miss_cnt != {CNT_W{1'b1}}))
        ret_miss_cnt <= ret_miss_cnt + 1'b1;
    end
  end
endmodule
